// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter designs.
//   MOD_BCD / MOD_HEX : common modulus choices
//   DIR_UP / DIR_DN   : encodings of the up_dn direction input
//   clog2()           : ceiling log2, usable in parameter expressions
package counter_pkg;

  localparam int   MOD_BCD = 10;
  localparam int   MOD_HEX = 16;
  localparam logic DIR_UP  = 1'b1;
  localparam logic DIR_DN  = 1'b0;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_ar.sv
// 1-bit edge-triggered D flip-flop with asynchronous active-low clear.
//   i_clk   : clock, captures on rising edge
//   i_clr_n : async clear, active low, forces o_q to 0
//   i_d     : data in
//   o_q     : registered data out
module dff_ar (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_d,
  output logic o_q
);

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) o_q <= 1'b0;
    else          o_q <= i_d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, enable prescaler and
// combinational terminal count for cascading digits. Every state bit
// is one dff_ar; all next-state logic lives here.
//   i_clk      : clock
//   i_clear_n  : async active-low reset of all state
//   i_en       : count enable, feeds the prescaler
//   i_up_dn    : direction, 1 = up, 0 = down
//   i_load     : synchronous load (beats a tick in the same cycle)
//   i_load_val : value to load, clamped to MODULUS-1
//   o_q        : current count
//   o_tc       : terminal count, combinational, drives next digit's en
//   o_wrap     : one-cycle pulse after a wrap-around edge
//   o_load_err : last load was clamped
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = MOD_BCD,
  parameter int PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_clear_n,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_load_err
);

  // Prescaler keeps at least one bit so PRESCALE=1 still elaborates;
  // in that case it stays 0 and the tick degenerates to i_en.
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam int NS = WIDTH + PW + 2;

  localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  // One extra bit so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_q, w_q_d;
  logic [PW-1:0]    r_pre, w_pre_d;
  logic             r_wrap, w_wrap_d;
  logic             r_err, w_err_d;
  logic             w_tick, w_at_end, w_clamp;
  logic [NS-1:0]    w_d, r_state;

  assign w_tick   = i_en & (r_pre == PRE_LAST);
  assign w_at_end = (i_up_dn == DIR_UP) ? (r_q == Q_MAX) : (r_q == '0);
  assign w_clamp  = ({1'b0, i_load_val} >= MOD_EXT);

  always_comb begin
    w_q_d    = r_q;
    w_pre_d  = r_pre;
    w_wrap_d = 1'b0;
    w_err_d  = r_err;
    if (i_load) begin
      w_q_d   = w_clamp ? Q_MAX : i_load_val;
      w_pre_d = '0;
      w_err_d = w_clamp;
    end else begin
      if (i_en) w_pre_d = w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        if (w_at_end) begin
          w_q_d    = (i_up_dn == DIR_UP) ? '0 : Q_MAX;
          w_wrap_d = 1'b1;
        end else begin
          w_q_d = (i_up_dn == DIR_UP) ? r_q + 1'b1 : r_q - 1'b1;
        end
      end
    end
  end

  assign w_d = {w_err_d, w_wrap_d, w_pre_d, w_q_d};
  assign {r_err, r_wrap, r_pre, r_q} = r_state;

  dff_ar u_ff [NS-1:0] (
    .i_clk   (i_clk),
    .i_clr_n (i_clear_n),
    .i_d     (w_d),
    .o_q     (r_state)
  );

  assign o_q        = r_q;
  assign o_wrap     = r_wrap;
  assign o_load_err = r_err;
  assign o_tc       = w_tick & w_at_end;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  // DUT A: defaults (mod 10, prescale 1)
  logic a_en, a_up, a_load;
  logic [3:0] a_lv, a_q;
  logic a_tc, a_wrap, a_err;
  // DUT P: prescale 3
  logic p_en, p_load;
  logic [3:0] p_lv, p_q;
  logic p_tc, p_wrap, p_err;
  // cascade: units -> tens
  logic c_en;
  logic [3:0] u_q, t_q;
  logic u_tc, u_wrap, u_err, t_tc, t_wrap, t_err;

  mod_updown_counter u_a (.i_clk(clk), .i_clear_n(clear_n), .i_en(a_en), .i_up_dn(a_up),
    .i_load(a_load), .i_load_val(a_lv), .o_q(a_q), .o_tc(a_tc), .o_wrap(a_wrap), .o_load_err(a_err));
  mod_updown_counter #(.PRESCALE(3)) u_p (.i_clk(clk), .i_clear_n(clear_n), .i_en(p_en),
    .i_up_dn(DIR_UP), .i_load(p_load), .i_load_val(p_lv), .o_q(p_q), .o_tc(p_tc),
    .o_wrap(p_wrap), .o_load_err(p_err));
  mod_updown_counter u_un (.i_clk(clk), .i_clear_n(clear_n), .i_en(c_en), .i_up_dn(DIR_UP),
    .i_load(1'b0), .i_load_val(4'd0), .o_q(u_q), .o_tc(u_tc), .o_wrap(u_wrap), .o_load_err(u_err));
  mod_updown_counter u_tn (.i_clk(clk), .i_clear_n(clear_n), .i_en(u_tc), .i_up_dn(DIR_UP),
    .i_load(1'b0), .i_load_val(4'd0), .o_q(t_q), .o_tc(t_tc), .o_wrap(t_wrap), .o_load_err(t_err));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { string tag; int sel; int exp; } sb_t;
  sb_t sbq[$];

  int m_q, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return 32'(a_q);
      1: return 32'(a_wrap);
      2: return 32'(a_err);
      3: return 32'(p_q);
      4: return 32'(p_wrap);
      5: return 32'(t_q) * 10 + 32'(u_q);
      6: return 32'(t_wrap);
      default: return 32'hdead;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  // advance one edge, then drain the scoreboard against DUT outputs
  task automatic tick_edge();
    sb_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  // one cycle on DUT A with reference model expectations
  task automatic step_a(input logic en, input logic up, input logic ld, input int lv);
    int w;
    a_en = en; a_up = up; a_load = ld; a_lv = 4'(lv);
    #1;
    chk("a_tc", 32'(a_tc), 32'(en && (up ? (m_q == 9) : (m_q == 0))));
    w = 0;
    if (ld) begin
      if (lv < 10) begin m_q = lv; m_err = 0; end
      else begin m_q = 9; m_err = 1; end
    end else if (en) begin
      if (up) begin
        if (m_q == 9) begin m_q = 0; w = 1; end else m_q++;
      end else begin
        if (m_q == 0) begin m_q = 9; w = 1; end else m_q--;
      end
    end
    push("a_q", 0, m_q);
    push("a_wrap", 1, w);
    push("a_err", 2, m_err);
    tick_edge();
  endtask

  task automatic step_p(input logic en, input logic ld, input int lv,
                        input int eq, input int ew, input int etc);
    p_en = en; p_load = ld; p_lv = 4'(lv);
    #1;
    chk("p_tc", 32'(p_tc), 32'(etc));
    push("p_q", 3, eq);
    push("p_wrap", 4, ew);
    tick_edge();
  endtask

  initial begin
    clear_n = 1'b0;
    a_en = 0; a_up = 1; a_load = 0; a_lv = 0;
    p_en = 0; p_load = 0; p_lv = 0;
    c_en = 0;
    m_q = 0; m_err = 0;
    #2;
    chk("rst_q", 32'(a_q), 0);
    chk("rst_wrap", 32'(a_wrap), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_pq", 32'(p_q), 0);
    #1 clear_n = 1'b1;

    // up count 0..9 then wrap to 0
    for (int i = 0; i < 10; i++) step_a(1, DIR_UP, 0, 0);
    chk("up_wrapped_q", 32'(a_q), 0);
    chk("up_wrap_pulse", 32'(a_wrap), 1);
    // down: 0 -> 9 with wrap, then five ticks to 4
    step_a(1, DIR_DN, 0, 0);
    for (int i = 0; i < 5; i++) step_a(1, DIR_DN, 0, 0);
    chk("down_q4", 32'(a_q), 4);
    // load clamp beats a same-cycle tick; in-range load clears error
    step_a(1, DIR_UP, 1, 12);
    chk("clamp_q", 32'(a_q), 9);
    chk("clamp_err", 32'(a_err), 1);
    step_a(0, DIR_UP, 1, 3);
    step_a(0, DIR_UP, 0, 0);
    step_a(1, DIR_UP, 1, 9);
    step_a(0, DIR_UP, 1, 10);
    step_a(0, DIR_UP, 0, 0);   // load_err holds between loads
    // wrap pending with error set, then async reset clears everything
    step_a(1, DIR_UP, 0, 0);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_wrap", 32'(a_wrap), 0);
    chk("arst_err", 32'(a_err), 0);
    m_q = 0; m_err = 0;
    #2 clear_n = 1'b1;
    // reset at q=7 between edges, then resume from 0
    step_a(0, DIR_UP, 1, 6);
    step_a(1, DIR_UP, 0, 0);
    chk("pre_rst_q7", 32'(a_q), 7);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_q", 32'(a_q), 0);
    chk("arst_wrap7", 32'(a_wrap), 0);
    m_q = 0; m_err = 0;
    #2 clear_n = 1'b1;
    step_a(1, DIR_UP, 0, 0);
    step_a(1, DIR_UP, 0, 0);
    // random mix against the model
    for (int i = 0; i < 60; i++)
      step_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)));
    a_en = 0; a_load = 0;

    // prescaler: steps at 3, 6, 9
    for (int k = 1; k <= 9; k++) step_p(1, 0, 0, k / 3, 0, 0);
    // en dropped for 2 cycles mid-period delays the step by 2
    step_p(1, 0, 0, 3, 0, 0);
    step_p(0, 0, 0, 3, 0, 0);
    step_p(0, 0, 0, 3, 0, 0);
    step_p(1, 0, 0, 3, 0, 0);
    step_p(1, 0, 0, 4, 0, 0);
    // load restarts the prescaler period
    step_p(1, 0, 0, 4, 0, 0);
    step_p(1, 1, 5, 5, 0, 0);
    step_p(1, 0, 0, 5, 0, 0);
    step_p(1, 0, 0, 5, 0, 0);
    step_p(1, 0, 0, 6, 0, 0);
    // tc only on the tick cycle at q=9
    step_p(0, 1, 9, 9, 0, 0);
    step_p(1, 0, 0, 9, 0, 0);
    step_p(1, 0, 0, 9, 0, 0);
    step_p(1, 0, 0, 0, 1, 1);
    p_en = 0;

    // cascade: 00..99 then 00, tens wrap once
    c_en = 1;
    for (int k = 1; k <= 101; k++) begin
      push("casc_val", 5, k % 100);
      push("casc_twrap", 6, (k == 100) ? 1 : 0);
      tick_edge();
    end
    c_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Synchronous modulo-N up/down counter with parallel load, enable prescaler and cascade terminal-count output. It is the counter stage built on top of the team's edge-triggered D flip-flop: every state bit is one async-clear D flop. Its `q`/`tc` outputs feed display decoders and higher-order counter digits in the Counters designs.

## Interface
- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 10: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- `PRESCALE`, 1: number of enabled cycles per count step. Must be ≥ 1.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `clear_n`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: count enable; feeds the prescaler.
- `up_dn`, input, 1: direction; 1 = up, 0 = down.
- `load`, input, 1: synchronous parallel load.
- `load_val`, input, WIDTH: value to load.
- `q`, output, WIDTH: current count (registered).
- `tc`, output, 1: terminal count / cascade enable (combinational).
- `wrap`, output, 1: registered one-cycle pulse after a wrap-around.
- `load_err`, output, 1: registered flag; last load was out of range.

## Operation
- Prescaler `pre_cnt` (width clog2(PRESCALE), minimum 1):
  - Advances only when `en`=1.
  - `tick` = `en` & (`pre_cnt` == PRESCALE-1), after which `pre_cnt` returns to 0.
  - Holds its value while `en`=0.
  - With PRESCALE=1, `tick` = `en`.
- Priority per edge: `clear_n` low > `load` > `tick` > hold.
- Load:
  - `q` ← `load_val` if `load_val` < MODULUS; otherwise `q` ← MODULUS-1.
  - `load_err` ← 1 when clamped, else 0.
  - `pre_cnt` ← 0 and `wrap` ← 0.
  - A `tick` in the same cycle is discarded.
- Tick, up direction: `q` ← `q`+1. When `q` == MODULUS-1, `q` ← 0 and `wrap` ← 1.
- Tick, down direction: `q` ← `q`-1. When `q` == 0, `q` ← MODULUS-1 and `wrap` ← 1.
- `wrap` is 0 on every edge that is not a wrapping tick.
- `load_err` holds between loads.
- `tc` = `tick` & (`up_dn` ? `q` == MODULUS-1 : `q` == 0). Chain it into the next digit's `en`, with PRESCALE=1 on that digit.
- `up_dn` is sampled at the tick edge. A direction change applies to the next step with no extra cycle.
- Arithmetic is WIDTH-bit unsigned. `q` never leaves 0..MODULUS-1. Out-of-range states are unreachable.

## Timing
- Reset (async, `clear_n` low): `q`=0, `pre_cnt`=0, `wrap`=0, `load_err`=0, immediately and independent of `clk`.
  - Deassertion is synchronous to the next rising edge.
  - Reset mid-count abandons the count with no residual pulse.
- Load latency: `q` shows the loaded value 1 cycle after the `load` edge.
- Count latency: `q` updates at the edge where `tick`=1. `en` to first step takes PRESCALE edges.
- `wrap` is high for exactly the cycle following the wrapping edge.
- `tc` has combinational dependence on `en`, `up_dn` and state, with no registered delay. This allows same-edge cascading.

## Structure
- Shared package `counter_pkg` holds:
  - default MODULUS constants (BCD=10, HEX=16);
  - direction encodings `DIR_UP`=1, `DIR_DN`=0;
  - the clog2 function.
- One sub-module, `dff_ar`: 1-bit D flop with async active-low clear.
  - Instantiated per bit of `q`, `pre_cnt`, `wrap` and `load_err`.
  - Next-state logic stays in `mod_updown_counter`.

## Test plan
- **Up count and wrap:** defaults, `en`=1, `up_dn`=1 from reset for 10 cycles → `q` runs 0..9 then 0; `wrap`=1 only in the cycle after 9→0; `tc`=1 only while `q`=9.
- **Down count:** `up_dn`=0 from `q`=0, one tick → `q`=9, `wrap`=1. Five more ticks → `q`=4.
- **Load clamp and priority:**
  - `load`=1, `load_val`=12, `en`=1 in the same cycle → `q`=9, `load_err`=1.
  - Next load of 3 → `q`=3, `load_err`=0.
- **Prescaler:** PRESCALE=3, `en`=1 for 9 cycles → `q` steps 0→1→2→3 at cycles 3, 6, 9. Drop `en` for 2 cycles mid-period → the step is delayed by exactly 2 cycles.
- **Async reset mid-count:** pull `clear_n` low between clock edges at `q`=7 → `q`=0 and `wrap`=0 before the next edge. Release → counting resumes from 0.
- **Cascade:** two instances, units `tc` → tens `en`, 100 cycles → pair counts 00..99 then 00; tens `wrap` pulses once.
